// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue between the PC/instruction memory and decode.
//
// A circular FIFO holding {addr, instr} per entry. Entries pushed at a rising edge
// become visible on dec_* after that edge; there is no bypass path when empty.
// A flush drops every queued (wrong-path) entry and resets both pointers.
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   fetch_valid  : fetch_addr/fetch_instr carry a new instruction this cycle
//   fetch_addr   : address of the fetched instruction (AW bits)
//   fetch_instr  : instruction word for fetch_addr (IW bits)
//   flush        : redirect; discard all queued entries and any same-cycle push/pop
//   fq_ready     : queue can accept a push (registered state only)
//   dec_ready    : decode accepts the head entry this cycle
//   dec_valid    : head entry valid
//   dec_instr    : head instruction
//   dec_pc       : head instruction address
//   dec_ret_addr : dec_pc + 4, wrapping modulo 2^AW (link address)
//   count        : number of occupied entries
//   flush_cnt    : (only with FQ_FLUSH_CNT_EN defined) saturating total of
//                  entries discarded by flushes
//
// Build option: define FQ_FLUSH_CNT_EN to add the flush_cnt output and its counter.

module fetch_queue #(
  parameter int AW    = 8,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid,
  input  logic [AW-1:0]              fetch_addr,
  input  logic [IW-1:0]              fetch_instr,
  input  logic                       flush,
  output logic                       fq_ready,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [IW-1:0]              dec_instr,
  output logic [AW-1:0]              dec_pc,
  output logic [AW-1:0]              dec_ret_addr,
  output logic [$clog2(DEPTH):0]     count
`ifdef FQ_FLUSH_CNT_EN
  ,
  output logic [7:0]                 flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem  [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Both flags come only from registered count, so fq_ready never depends on dec_ready.
  assign fq_ready  = (count_q != CW'(DEPTH));
  assign dec_valid = (count_q != '0);
  assign push      = fetch_valid && fq_ready && !flush;
  assign pop       = dec_valid && dec_ready && !flush;

  assign count        = count_q;
  assign dec_instr    = instr_mem[rd_ptr];
  assign dec_pc       = addr_mem[rd_ptr];
  assign dec_ret_addr = dec_pc + AW'(4);

  // DEPTH is a power of two, so PW-bit pointer increments wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; a stray write during reset lands in a slot that count marks empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= fetch_addr;
      instr_mem[wr_ptr] <= fetch_instr;
    end
  end

`ifdef FQ_FLUSH_CNT_EN
  logic [8:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt} + 9'(count_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (flush) begin
      flush_cnt <= flush_sum[8] ? 8'hFF : flush_sum[7:0];
    end
  end
`endif

endmodule
